seq_code_checker: RTL and testbench

//   Receive-side checker for the 3-bit ring-code counter stream.

---
 rtl/seq_code_pkg.sv | 48 ++++
 rtl/seq_next_logic.sv | 12 +
 rtl/seq_code_checker.sv | 149 ++++++++++++++
 tb/tb_seq_code_checker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_code_pkg.sv
// Shared definitions for the 3-bit ring-code counter and its receive-side checker:
// ring constants, checker state encoding and the NEXT()/ring-position helpers.
package seq_code_pkg;

    localparam logic [2:0] R0 = 3'b000;
    localparam logic [2:0] R1 = 3'b110;
    localparam logic [2:0] R2 = 3'b100;
    localparam logic [2:0] R3 = 3'b111;
    localparam logic [2:0] R4 = 3'b011;

    localparam logic [2:0] IDX_NONE = 3'd7;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_t;

    // Off-ring codes are folded back onto the ring within one or two steps.
    function automatic logic [2:0] next_code(input logic [2:0] c);
        case (c)
            3'b000:  return 3'b110;
            3'b001:  return 3'b110;
            3'b010:  return 3'b111;
            3'b011:  return 3'b000;
            3'b100:  return 3'b111;
            3'b101:  return 3'b010;
            3'b110:  return 3'b100;
            default: return 3'b011;
        endcase
    endfunction

    function automatic logic [2:0] code_index(input logic [2:0] c);
        case (c)
            R0:      return 3'd0;
            R1:      return 3'd1;
            R2:      return 3'd2;
            R3:      return 3'd3;
            R4:      return 3'd4;
            default: return IDX_NONE;
        endcase
    endfunction

    function automatic logic on_ring(input logic [2:0] c);
        return code_index(c) != IDX_NONE;
    endfunction

endpackage

// File: rtl/seq_next_logic.sv
// Combinational NEXT() gate network of the ring-code counter, shared by the
// transmitter and this checker so both sides follow identical sequencing.
module seq_next_logic (
    input  logic [2:0] code_cur,
    output logic [2:0] code_nxt
);

    assign code_nxt[2] = ~(code_cur[0] & (code_cur[1] | code_cur[2]));
    assign code_nxt[1] = ~(code_cur[1] & (code_cur[2] ^ code_cur[0]));
    assign code_nxt[0] = (~code_cur[0] & (code_cur[2] ^ code_cur[1])) | (&code_cur);

endmodule

// File: rtl/seq_code_checker.sv
// Receive-side checker for the ring-code stream: hunts for an on-ring code,
// verifies LOCK_THRESH correct transitions, then tracks and flags mispredictions.
module seq_code_checker
    import seq_code_pkg::*;
#(
    parameter int unsigned LOCK_THRESH = 4,
    parameter int unsigned LOSS_THRESH = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             code_valid,
    input  logic [2:0]       code_in,
    input  logic             load_en,
    input  logic [2:0]       load_val,
    output logic             locked,
    output logic             err,
    output logic [2:0]       index,
    output logic [2:0]       expected,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [3:0]       LOCK_T  = 4'(LOCK_THRESH);
    localparam logic [3:0]       LOSS_T  = 4'(LOSS_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [3:0]       good_q, good_d, bad_q, bad_d;
    logic [3:0]       good_inc, bad_inc;
    logic             locked_d, err_d, upd_exp;
    logic [2:0]       index_d, pred, exp_next;
    logic [CNT_W-1:0] cnt_d;

    // Prediction for the sample arriving now comes from the stored prev; the
    // registered expected output is refreshed from whatever prev becomes.
    assign pred = next_code(prev_q);

    seq_next_logic u_next (
        .code_cur (prev_d),
        .code_nxt (exp_next)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        prev_d   = prev_q;
        good_d   = good_q;
        bad_d    = bad_q;
        locked_d = locked;
        err_d    = 1'b0;
        index_d  = index;
        cnt_d    = err_count;
        upd_exp  = 1'b0;
        good_inc = good_q + 4'd1;
        bad_inc  = bad_q + 4'd1;

        if (load_en) begin
            prev_d   = load_val;
            good_d   = 4'd0;
            bad_d    = 4'd0;
            state_d  = VERIFY;
            locked_d = 1'b0;
            index_d  = code_index(load_val);
            upd_exp  = 1'b1;
        end else if (code_valid) begin
            index_d = code_index(code_in);
            upd_exp = 1'b1;
            case (state_q)
                HUNT: begin
                    if (on_ring(code_in)) begin
                        prev_d  = code_in;
                        good_d  = 4'd0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (code_in == pred) begin
                        prev_d = code_in;
                        good_d = good_inc;
                        if (good_inc == LOCK_T) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            bad_d    = 4'd0;
                        end
                    end else if (on_ring(code_in)) begin
                        prev_d = code_in;
                        good_d = 4'd0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (code_in == pred) begin
                        prev_d = code_in;
                        bad_d  = 4'd0;
                    end else begin
                        err_d  = 1'b1;
                        bad_d  = bad_inc;
                        // An off-ring sample cannot re-seed the ring; coast on the prediction.
                        prev_d = on_ring(code_in) ? code_in : pred;
                        if (err_count != CNT_MAX) begin
                            cnt_d = err_count + 1'b1;
                        end
                        if (bad_inc == LOSS_T) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                            good_d   = 4'd0;
                            bad_d    = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= HUNT;
            prev_q    <= 3'b000;
            good_q    <= 4'd0;
            bad_q     <= 4'd0;
            locked    <= 1'b0;
            err       <= 1'b0;
            index     <= IDX_NONE;
            expected  <= 3'b000;
            err_count <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            prev_q    <= prev_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            locked    <= locked_d;
            err       <= err_d;
            index     <= index_d;
            err_count <= cnt_d;
            if (upd_exp) begin
                expected <= exp_next;
            end
        end
    end

endmodule

// File: tb/tb_seq_code_checker.sv
// Self-checking bench for seq_code_checker: directed scenarios plus randomized
// traffic, all compared against a table-driven behavioural model.
module tb_seq_code_checker;

    localparam int LOCK_THRESH = 4;
    localparam int LOSS_THRESH = 2;
    localparam int CNT_W       = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    localparam int M_HUNT   = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic             clk = 1'b0;
    logic             clr;
    logic             code_valid;
    logic [2:0]       code_in;
    logic             load_en;
    logic [2:0]       load_val;
    logic             locked;
    logic             err;
    logic [2:0]       index;
    logic [2:0]       expected;
    logic [CNT_W-1:0] err_count;

    always #5 clk = ~clk;

    seq_code_checker #(
        .LOCK_THRESH (LOCK_THRESH),
        .LOSS_THRESH (LOSS_THRESH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .code_valid (code_valid),
        .code_in    (code_in),
        .load_en    (load_en),
        .load_val   (load_val),
        .locked     (locked),
        .err        (err),
        .index      (index),
        .expected   (expected),
        .err_count  (err_count)
    );

    int errors = 0;
    int checks = 0;

    // Ring order and the full successor table, straight from the code definition.
    int ring[5]    = '{0, 6, 4, 7, 3};
    int nxt_tbl[8] = '{6, 6, 7, 0, 7, 2, 4, 3};

    int m_state, m_prev, m_good, m_bad, m_locked, m_err, m_index, m_expected, m_cnt;

    function automatic int nxt(input int c);
        return nxt_tbl[c & 7];
    endfunction

    function automatic int ring_pos(input int c);
        for (int i = 0; i < 5; i++) begin
            if (ring[i] == c) return i;
        end
        return 7;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_HUNT; m_prev = 0; m_good = 0; m_bad = 0;
        m_locked = 0; m_err = 0; m_index = 7; m_expected = 0; m_cnt = 0;
    endtask

    task automatic model_step(input int c_clr, input int v, input int c, input int ld, input int lv);
        int pred;
        bit ok_ring;
        if (c_clr != 0) begin
            model_reset();
            return;
        end
        m_err = 0;
        if (ld != 0) begin
            m_prev = lv; m_good = 0; m_bad = 0;
            m_state = M_VERIFY; m_locked = 0;
            m_index = ring_pos(lv);
            m_expected = nxt(m_prev);
        end else if (v != 0) begin
            pred    = nxt(m_prev);
            ok_ring = (ring_pos(c) != 7);
            m_index = ring_pos(c);
            if (m_state == M_HUNT) begin
                if (ok_ring) begin
                    m_prev = c; m_good = 0; m_state = M_VERIFY;
                end
            end else if (m_state == M_VERIFY) begin
                if (c == pred) begin
                    m_good++; m_prev = c;
                    if (m_good == LOCK_THRESH) begin
                        m_state = M_LOCKED; m_locked = 1; m_bad = 0;
                    end
                end else if (ok_ring) begin
                    m_prev = c; m_good = 0;
                end else begin
                    m_state = M_HUNT;
                end
            end else begin
                if (c == pred) begin
                    m_prev = c; m_bad = 0;
                end else begin
                    m_err = 1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_bad++;
                    m_prev = ok_ring ? c : pred;
                    if (m_bad == LOSS_THRESH) begin
                        m_state = M_HUNT; m_locked = 0; m_good = 0;
                    end
                end
            end
            m_expected = nxt(m_prev);
        end
    endtask

    task automatic compare_all(input string ph);
        check({ph, ".locked"},    32'(locked),    m_locked);
        check({ph, ".err"},       32'(err),       m_err);
        check({ph, ".index"},     32'(index),     m_index);
        check({ph, ".expected"},  32'(expected),  m_expected);
        check({ph, ".err_count"}, 32'(err_count), m_cnt);
    endtask

    task automatic step(input string ph, input int c_clr, input int v, input int c,
                        input int ld, input int lv);
        @(negedge clk);
        clr        = c_clr[0];
        code_valid = v[0];
        code_in    = 3'(c);
        load_en    = ld[0];
        load_val   = 3'(lv);
        @(posedge clk);
        model_step(c_clr, v, c, ld, lv);
        #1;
        compare_all(ph);
    endtask

    task automatic feed_ring(input string ph);
        for (int i = 0; i < 5; i++) begin
            step(ph, 0, 1, ring[i], 0, 0);
        end
    endtask

    initial begin
        clr = 1'b1; code_valid = 1'b0; code_in = 3'd0; load_en = 1'b0; load_val = 3'd0;
        model_reset();
        step("rst", 1, 0, 0, 0, 0);
        step("rst", 1, 0, 0, 0, 0);
        check("rst_index", 32'(index), 7);
        check("rst_expected", 32'(expected), 0);
        check("rst_locked", 32'(locked), 0);

        // 1: clean ring acquisition
        for (int i = 0; i < 5; i++) begin
            step("t1", 0, 1, ring[i], 0, 0);
            check("t1_index", 32'(index), i);
            check("t1_err", 32'(err), 0);
            check("t1_locked", 32'(locked), (i == 4) ? 1 : 0);
        end

        // idle cycles hold state
        step("idle", 0, 0, 5, 0, 0);
        step("idle", 0, 0, 2, 0, 0);
        check("idle_expected", 32'(expected), 0);

        // 2: off-ring glitch while locked, flywheel
        step("t2", 0, 1, 5, 0, 0);
        check("t2_err", 32'(err), 1);
        check("t2_cnt", 32'(err_count), 1);
        check("t2_expected", 32'(expected), 6);
        check("t2_locked", 32'(locked), 1);
        step("t2", 0, 1, 6, 0, 0);
        check("t2_err_clear", 32'(err), 0);

        // 3: two consecutive on-ring mispredictions drop lock
        step("t3", 0, 1, 4, 0, 0);
        step("t3", 0, 1, 7, 0, 0);
        step("t3", 0, 1, 3, 0, 0);
        step("t3", 0, 1, 6, 0, 0);
        check("t3_err1", 32'(err), 1);
        check("t3_locked1", 32'(locked), 1);
        step("t3", 0, 1, 0, 0, 0);
        check("t3_err2", 32'(err), 1);
        check("t3_locked2", 32'(locked), 0);
        check("t3_cnt", 32'(err_count), 3);

        // 4: parallel load of an off-ring value while locked
        feed_ring("t4");
        check("t4_relocked", 32'(locked), 1);
        step("t4", 0, 1, 6, 1, 5);
        check("t4_locked", 32'(locked), 0);
        check("t4_expected", 32'(expected), 2);
        check("t4_cnt", 32'(err_count), 3);
        step("t4", 0, 1, 2, 0, 0);
        step("t4", 0, 1, 7, 0, 0);
        step("t4", 0, 1, 3, 0, 0);
        step("t4", 0, 1, 0, 0, 0);
        step("t4", 0, 1, 6, 0, 0);
        check("t4_lock_again", 32'(locked), 1);

        // 5: err_count saturation, then clr beats load and valid
        for (int i = 0; i < 300; i++) begin
            step("t5", 0, 1, 5, 0, 0);
            step("t5", 0, 1, nxt(m_prev), 0, 0);
        end
        check("t5_sat", 32'(err_count), CNT_MAX);
        check("t5_locked", 32'(locked), 1);
        step("t5c", 1, 1, 3, 1, 5);
        check("t5_clr_cnt", 32'(err_count), 0);
        check("t5_clr_index", 32'(index), 7);
        check("t5_clr_locked", 32'(locked), 0);

        // randomized traffic: mostly-correct stream with glitches, loads, idles, clears
        for (int n = 0; n < 3000; n++) begin
            int r, v, c, ld, cl;
            r  = int'($urandom_range(0, 99));
            cl = (r == 0) ? 1 : 0;
            ld = (r >= 1 && r <= 4) ? 1 : 0;
            v  = (r >= 20) ? 1 : 0;
            if ($urandom_range(0, 9) < 8) c = nxt(m_prev);
            else c = int'($urandom_range(0, 7));
            step("rnd", cl, v, c, ld, int'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
